// File: rtl/uart_pkg.sv
// Shared UART definitions (FSM states, bit-period helper, line idle level), reused by the TX and RX sides.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE = 1'b1;

  function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_gen.sv
// Bit-period counter: tick pulses on count CLKS_PER_BIT-1, pre_tick one cycle earlier.
// Latency: clr takes effect at the next edge (count 0); no backpressure.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick     = (cnt_q == LAST_CNT);
  assign pre_tick = (cnt_q == PRE_CNT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART TX serializer: pops a FWFT FIFO word when idle, sends start/data(LSB first)/[parity]/stop; UART_TX_PARITY_EN adds the parity bit.
// Latency: tx falls the cycle after the pop; next pop the cycle after done. Backpressure: no pop while a frame is in flight.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int DATA_WIDTH  = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || DATA_WIDTH < 5 || DATA_WIDTH > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_serializer: unsupported parameter set");
  end

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  rd_en_q, rd_en_d;
  logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic baud_clr;
  logic tick;
  logic pre_tick;

  // Holding the counter cleared while idle makes every frame start on count 0.
  assign baud_clr = (state_q == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rd_en_q) begin
          shift_d   = fifo_data;
          bit_cnt_d = '0;
          state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^fifo_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // done is registered, so it is launched one cycle ahead of the final stop cycle.
        done_d = pre_tick && (bit_cnt_q == LAST_STOP);
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_en_d = (state_d == ST_IDLE) && !fifo_empty;
    busy_d  = (state_d != ST_IDLE) || rd_en_d;

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= UART_IDLE;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: instance 0 default, 1 with two stop bits, 2 with odd parity.
module tb_uart_tx_serializer;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  typedef struct {
    logic [15:0] bits;
    int          nbits;
  } frame_t;

  logic       clk;
  logic       rst;
  logic [7:0] fifo_data;
  logic [2:0] fifo_empty_v;
  logic [2:0] rd_v, tx_v, busy_v, done_v;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         sel = 0;
  logic       pop_pending = 1'b0;
  logic       s_tx, s_rd, s_busy, s_done;
  int         last_pop_cyc = -1;
  int         last_done_cyc = -1;
  logic [7:0] fifo_q[$];
  frame_t     exp_q[$];

  uart_tx_serializer #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_WIDTH(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty_v[0]),
    .fifo_rd_en(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  uart_tx_serializer #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_WIDTH(8), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty_v[1]),
    .fifo_rd_en(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  uart_tx_serializer #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_WIDTH(8), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty_v[2]),
    .fifo_rd_en(rd_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic frame_t build_frame(input logic [7:0] d, input int stop_bits, input int odd);
    frame_t f;
    int k;
    f.bits = '0;
    k = 0;
    f.bits[k] = 1'b0;
    k++;
    for (int i = 0; i < 8; i++) begin
      f.bits[k] = d[i];
      k++;
    end
    if (PEN != 0) begin
      f.bits[k] = (^d) ^ (odd != 0);
      k++;
    end
    for (int s = 0; s < stop_bits; s++) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.nbits = k;
    return f;
  endfunction

  task automatic drive_fifo();
    fifo_empty_v      = 3'b111;
    fifo_empty_v[sel] = (fifo_q.size() == 0);
    fifo_data         = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] d, input int stop_bits, input int odd);
    fifo_q.push_back(d);
    exp_q.push_back(build_frame(d, stop_bits, odd));
    drive_fifo();
  endtask

  // One clock: retire a pop seen last cycle, refresh FIFO inputs, sample the selected instance.
  task automatic step();
    @(posedge clk);
    if (pop_pending) begin
      checks++;
      if (fifo_q.size() == 0) begin
        failures++;
        $display("FAIL pop_when_empty cycle=%0d fifo_rd_en=1 required=0", cyc);
      end else begin
        void'(fifo_q.pop_front());
      end
    end
    #1;
    drive_fifo();
    s_tx   = tx_v[sel];
    s_rd   = rd_v[sel];
    s_busy = busy_v[sel];
    s_done = done_v[sel];
    pop_pending = s_rd;
    cyc++;
  endtask

  task automatic capture_frame(input string name);
    frame_t exp;
    int     waited;
    int     done_cnt;
    int     done_at;
    int     rd_mid;
    int     busy_lo;
    logic   bad;
    logic   bad_val;
    waited = 0;
    while (!s_rd && waited < 3000) begin
      step();
      waited++;
    end
    checks++;
    if (!s_rd) begin
      failures++;
      $display("FAIL %s pop_timeout fifo_rd_en=0 after %0d cycles required=1", name, waited);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    last_pop_cyc = cyc;
    exp = exp_q.pop_front();
    checks++;
    if (s_busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_at_pop got=%b required=1", name, s_busy);
    end
    checks++;
    if (s_tx !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_at_pop tx=%b required=1", name, s_tx);
    end
    done_cnt = 0;
    done_at  = -1;
    rd_mid   = 0;
    busy_lo  = 0;
    for (int b = 0; b < exp.nbits; b++) begin
      bad     = 1'b0;
      bad_val = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        step();
        if (s_tx !== exp.bits[b] && !bad) begin
          bad     = 1'b1;
          bad_val = s_tx;
        end
        if (s_rd) rd_mid++;
        if (s_busy !== 1'b1) busy_lo++;
        if (s_done) begin
          done_cnt++;
          done_at = cyc;
        end
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s line_bit%0d tx=%b required=%b", name, b, bad_val, exp.bits[b]);
      end
    end
    last_done_cyc = done_at;
    checks++;
    if (done_cnt != 1 || done_at - last_pop_cyc != exp.nbits * CPB) begin
      failures++;
      $display("FAIL %s done_timing pulses=%0d offset=%0d required 1 pulse at offset %0d",
               name, done_cnt, done_at - last_pop_cyc, exp.nbits * CPB);
    end
    checks++;
    if (rd_mid != 0) begin
      failures++;
      $display("FAIL %s pop_mid_frame count=%0d required=0", name, rd_mid);
    end
    checks++;
    if (busy_lo != 0) begin
      failures++;
      $display("FAIL %s busy_mid_frame low_cycles=%0d required=0", name, busy_lo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (tx_v !== 3'b111) begin failures++; $display("FAIL reset_tx got=%b required=111", tx_v); end
    checks++;
    if (rd_v !== 3'b000) begin failures++; $display("FAIL reset_rd_en got=%b required=000", rd_v); end
    checks++;
    if (busy_v !== 3'b000) begin failures++; $display("FAIL reset_busy got=%b required=000", busy_v); end
    checks++;
    if (done_v !== 3'b000) begin failures++; $display("FAIL reset_done got=%b required=000", done_v); end
    rst = 1'b0;
    repeat (2) step();
    checks++;
    if (tx_v !== 3'b111 || rd_v !== 3'b000 || busy_v !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle tx=%b rd=%b busy=%b required 111/000/000", tx_v, rd_v, busy_v);
    end
  endtask

  task automatic test_single_byte();
    int extra_rd;
    sel = 0;
    push_byte(8'hA5, 1, 0);
    capture_frame("single_a5");
    step();
    checks++;
    if (s_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after_done got=%b required=0", s_busy); end
    extra_rd = s_rd ? 1 : 0;
    repeat (20) begin
      step();
      if (s_rd) extra_rd++;
    end
    checks++;
    if (extra_rd != 0) begin failures++; $display("FAIL single_extra_pops count=%0d required=0", extra_rd); end
  endtask

  task automatic test_back_to_back();
    int first_done;
    sel = 0;
    push_byte(8'h00, 1, 0);
    push_byte(8'hFF, 1, 0);
    capture_frame("b2b_00");
    first_done = last_done_cyc;
    capture_frame("b2b_ff");
    checks++;
    if (last_pop_cyc - first_done != 1) begin
      failures++;
      $display("FAIL b2b_pop_gap got=%0d required=1", last_pop_cyc - first_done);
    end
    step();
    checks++;
    if (s_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_after_done got=%b required=0", s_busy); end
  endtask

  task automatic test_empty();
    int n_rd = 0;
    int n_txlo = 0;
    int n_busy = 0;
    sel = 0;
    drive_fifo();
    repeat (500) begin
      step();
      if (s_rd) n_rd++;
      if (s_tx !== 1'b1) n_txlo++;
      if (s_busy) n_busy++;
    end
    checks++;
    if (n_rd != 0) begin failures++; $display("FAIL empty_rd_en count=%0d required=0", n_rd); end
    checks++;
    if (n_txlo != 0) begin failures++; $display("FAIL empty_tx_low count=%0d required=0", n_txlo); end
    checks++;
    if (n_busy != 0) begin failures++; $display("FAIL empty_busy count=%0d required=0", n_busy); end
  endtask

  task automatic test_reset_mid_frame();
    int waited = 0;
    int n_done = 0;
    int n_rd = 0;
    int n_txlo = 0;
    int n_busy = 0;
    sel = 0;
    push_byte(8'h3C, 1, 0);
    while (!s_rd && waited < 3000) begin
      step();
      waited++;
    end
    checks++;
    if (!s_rd) begin failures++; $display("FAIL rstmid_pop_timeout fifo_rd_en=0 required=1"); end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (35) step();
    checks++;
    if (s_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b required=1", s_busy); end
    rst = 1'b1;
    step();
    checks++;
    if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_next_clock tx=%b busy=%b done=%b required 1/0/0", s_tx, s_busy, s_done);
    end
    rst = 1'b0;
    repeat (200) begin
      step();
      if (s_done) n_done++;
      if (s_rd) n_rd++;
      if (s_tx !== 1'b1) n_txlo++;
      if (s_busy) n_busy++;
    end
    checks++;
    if (n_done != 0) begin failures++; $display("FAIL rstmid_done count=%0d required=0", n_done); end
    checks++;
    if (n_rd != 0) begin failures++; $display("FAIL rstmid_repop count=%0d required=0", n_rd); end
    checks++;
    if (n_txlo != 0 || n_busy != 0) begin
      failures++;
      $display("FAIL rstmid_after tx_low=%0d busy=%0d required 0/0", n_txlo, n_busy);
    end
  endtask

  task automatic test_two_stop();
    sel = 1;
    drive_fifo();
    step();
    push_byte(8'h81, 2, 0);
    capture_frame("stop2_81");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    sel = 0;
    drive_fifo();
    step();
    push_byte(8'h07, 1, 0);
    capture_frame("parity_even_07");
    sel = 2;
    drive_fifo();
    step();
    push_byte(8'h07, 1, 1);
    capture_frame("parity_odd_07");
  endtask
`endif

  initial begin
    rst          = 1'b1;
    fifo_data    = 8'h00;
    fifo_empty_v = 3'b111;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty();
    test_reset_mid_frame();
    test_two_stop();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
